// File: rtl/sm_pkg.sv
// Shared definitions for the sequence-detector family: FSM state encoding and
// width helpers used by the w stimulus generator and the detector benches.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Bits needed to hold a length in 0..pat_w.
  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Tick counter width; a divider of 1 still keeps a one-bit register.
  function automatic int unsigned cnt_w(input int unsigned tick_div);
    return (tick_div < 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/w_sequence_gen_if.sv
// Control/data bundle between a pattern source and the w sequence generator.
interface w_sequence_gen_if #(
  parameter int unsigned PAT_W = 8
) ();

  localparam int unsigned LEN_W = sm_pkg::len_w(PAT_W);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             repeat_en;
  logic             abort;
  logic             w;
  logic             w_strobe;
  logic             busy;
  logic             done;
  logic             len_err;
  logic [LEN_W-1:0] bit_idx;

  modport master (
    output start, pattern, pat_len, repeat_en, abort,
    input  w, w_strobe, busy, done, len_err, bit_idx
  );

  modport slave (
    input  start, pattern, pat_len, repeat_en, abort,
    output w, w_strobe, busy, done, len_err, bit_idx
  );

endinterface

// File: rtl/w_sequence_gen_tick.sv
// Bit-period enable generator: one-cycle tick every TICK_DIV enabled clocks,
// used instead of a divided clock so all logic stays on CLOCK_50.
module bit_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  import sm_pkg::*;

  localparam int unsigned          CNT_W   = cnt_w(TICK_DIV);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap exactly at TICK_DIV-1 so the counter never needs an overflow path.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == CNT_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/w_sequence_gen.sv
// Serial stimulus source for the detector input w: captures a pattern and
// shifts it out MSB-first, one bit per TICK_DIV clocks, once or repeating.
module w_sequence_gen #(
  parameter int unsigned PAT_W    = 8,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  w_sequence_gen_if.slave  bus
);

  import sm_pkg::*;

  localparam int unsigned      LEN_W   = len_w(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_e           state_q,    state_d;
  logic [PAT_W-1:0] shadow_q,   shadow_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [LEN_W-1:0] bit_idx_q,  bit_idx_d;
  logic             w_q,        w_d;
  logic             w_strobe_q, w_strobe_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             len_err_q,  len_err_d;

  logic             tick_c;
  logic             tick_clr_c;
  logic             tick_en_c;
  logic             len_bad_c;
  logic [LEN_W-1:0] nxt_idx_c;

  assign tick_en_c = (state_q == SHIFT);
  assign len_bad_c = (bus.pat_len == '0) || (bus.pat_len > LEN_MAX);

  bit_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr      (tick_clr_c),
    .en       (tick_en_c),
    .tick     (tick_c)
  );

  // Next-state and registered-output decode; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    len_d      = len_q;
    bit_idx_d  = bit_idx_q;
    w_d        = w_q;
    w_strobe_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    len_err_d  = 1'b0;
    tick_clr_c = 1'b0;
    nxt_idx_c  = '0;

    if (bus.abort) begin
      state_d    = IDLE;
      w_d        = 1'b0;
      busy_d     = 1'b0;
      bit_idx_d  = '0;
      tick_clr_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (len_bad_c) begin
              len_err_d = 1'b1;
            end else begin
              nxt_idx_c  = bus.pat_len - LEN_W'(1);
              state_d    = SHIFT;
              busy_d     = 1'b1;
              shadow_d   = bus.pattern;
              len_d      = bus.pat_len;
              bit_idx_d  = nxt_idx_c;
              w_d        = 1'(bus.pattern >> nxt_idx_c);
              w_strobe_d = 1'b1;
              tick_clr_c = 1'b1;
            end
          end
        end

        SHIFT: begin
          if (tick_c) begin
            if (bit_idx_q != '0) begin
              nxt_idx_c  = bit_idx_q - LEN_W'(1);
              bit_idx_d  = nxt_idx_c;
              w_d        = 1'(shadow_q >> nxt_idx_c);
              w_strobe_d = 1'b1;
            end else if (bus.repeat_en) begin
              // Wrap straight into the next pass with no idle gap.
              nxt_idx_c  = len_q - LEN_W'(1);
              bit_idx_d  = nxt_idx_c;
              w_d        = 1'(shadow_q >> nxt_idx_c);
              w_strobe_d = 1'b1;
            end else begin
              state_d = FINISH;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end

        FINISH: begin
          state_d   = IDLE;
          w_d       = 1'b0;
          bit_idx_d = '0;
        end

        default: begin
          state_d   = IDLE;
          w_d       = 1'b0;
          busy_d    = 1'b0;
          bit_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      len_q      <= '0;
      bit_idx_q  <= '0;
      w_q        <= 1'b0;
      w_strobe_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      len_q      <= len_d;
      bit_idx_q  <= bit_idx_d;
      w_q        <= w_d;
      w_strobe_q <= w_strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

  assign bus.w        = w_q;
  assign bus.w_strobe = w_strobe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.len_err  = len_err_q;
  assign bus.bit_idx  = bit_idx_q;

endmodule

// File: tb/tb_w_sequence_gen.sv
// Directed bench for w_sequence_gen: per-cycle model checks plus a bit
// scoreboard popped on every w_strobe; second instance uses TICK_DIV=1.
module tb_w_sequence_gen;

  localparam int unsigned PAT_W = 8;
  localparam int          TD    = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  w_sequence_gen_if #(.PAT_W(PAT_W)) bus  ();
  w_sequence_gen_if #(.PAT_W(PAT_W)) bus1 ();

  w_sequence_gen #(.PAT_W(PAT_W), .TICK_DIV(TD)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  w_sequence_gen #(.PAT_W(PAT_W), .TICK_DIV(1)) dut1 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:0] sb_q[$];
  logic [4:0] sb_e;

  // Observed vector layout: {w, w_strobe, busy, done, len_err, bit_idx[3:0]}
  function automatic logic [8:0] vec0();
    return {bus.w, bus.w_strobe, bus.busy, bus.done, bus.len_err, bus.bit_idx};
  endfunction

  function automatic logic [8:0] vec1();
    return {bus1.w, bus1.w_strobe, bus1.busy, bus1.done, bus1.len_err, bus1.bit_idx};
  endfunction

  // Expected outputs k cycles after start is sampled (k=1 is the first output cycle).
  function automatic logic [8:0] model(input logic [7:0] pat, input int len,
                                       input int passes, input int tdiv, input int k);
    int n;
    int j;
    int idx;
    logic [8:0] v;
    v = '0;
    if (len < 1 || len > 8) begin
      if (k == 1) v[4] = 1'b1;
      return v;
    end
    n = passes * len * tdiv;
    if (k >= 1 && k <= n) begin
      j      = (k - 1) % (len * tdiv);
      idx    = len - 1 - j / tdiv;
      v[8]   = 1'(pat >> idx);
      v[7]   = (j % tdiv == 0);
      v[6]   = 1'b1;
      v[3:0] = 4'(idx);
    end else if (k == n + 1) begin
      v[8] = pat[0];
      v[5] = 1'b1;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input logic [7:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) sb_q.push_back({1'(pat >> i), 4'(i)});
  endtask

  // Each new bit on w must match the next queued {bit, index}.
  always @(negedge clk) begin
    if (bus.w_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_strobe", 9'd1, 9'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_bit", {4'b0, bus.w, bus.bit_idx}, {4'b0, sb_e});
      end
    end
  end

  // Called at a negedge: drives start and checks every cycle until idle.
  task automatic run_tx(input logic [7:0] pat, input int len, input logic rep,
                        input int passes, input int clr_rep_at, input bit interfere,
                        input string name);
    int total;
    bit legal;
    legal = (len >= 1 && len <= 8);
    if (legal) for (int p = 0; p < passes; p++) push_pass(pat, len);
    total = legal ? passes * len * TD + 2 : 2;
    bus.pattern   = pat;
    bus.pat_len   = 4'(len);
    bus.repeat_en = rep;
    bus.start     = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("%s k=%0d", name, k), vec0(), model(pat, len, passes, TD, k));
      if (k == clr_rep_at) bus.repeat_en = 1'b0;
      if (interfere) begin
        if (k == 3) begin
          bus.start   = 1'b1;
          bus.pattern = 8'hFF;
          bus.pat_len = 4'd8;
        end
        if (k == 6) bus.pattern = 8'h00;
      end
    end
    bus.repeat_en = 1'b0;
    check({name, " sb_empty"}, 9'(sb_q.size()), 9'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.pattern    = 8'h0D;
    bus.pat_len    = 4'd4;
    bus.repeat_en  = 1'b0;
    bus.abort      = 1'b0;
    bus1.start     = 1'b0;
    bus1.pattern   = 8'h00;
    bus1.pat_len   = 4'd0;
    bus1.repeat_en = 1'b0;
    bus1.abort     = 1'b0;

    // Reset held with start asserted
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("reset k=%0d", k), vec0(), 9'd0);
      check($sformatf("reset1 k=%0d", k), vec1(), 9'd0);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", vec0(), 9'd0);

    run_tx(8'h0D, 4, 1'b0, 1, 0, 1'b0, "single");
    run_tx(8'h01, 4, 1'b1, 3, 40, 1'b0, "repeat");
    run_tx(8'h5A, 0, 1'b0, 1, 0, 1'b0, "len0");
    run_tx(8'hFF, 9, 1'b0, 1, 0, 1'b0, "len9");

    // Abort during cycle 6, restart accepted in cycle 8
    push_pass(8'h0D, 4);
    bus.pattern = 8'h0D;
    bus.pat_len = 4'd4;
    bus.start   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("abort k=%0d", k), vec0(), model(8'h0D, 4, 1, TD, k));
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort k=7", vec0(), 9'd0);
    sb_q.delete();
    @(negedge clk);
    check("abort k=8", vec0(), 9'd0);
    run_tx(8'h0D, 4, 1'b0, 1, 0, 1'b0, "after_abort");

    // Abort and start together: abort wins
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_start k=1", vec0(), 9'd0);
    @(negedge clk);
    check("abort_start k=2", vec0(), 9'd0);

    run_tx(8'h0D, 4, 1'b0, 1, 0, 1'b1, "interfere");

    // Reset mid-transmission beats start and abort
    sb_q.push_back({1'b1, 4'd3});
    bus.pattern = 8'h0D;
    bus.pat_len = 4'd4;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("midreset k=1", vec0(), model(8'h0D, 4, 1, TD, 1));
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("midreset k=2", vec0(), 9'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("midreset k=3", vec0(), 9'd0);
    check("midreset sb_empty", 9'(sb_q.size()), 9'd0);

    // TICK_DIV=1 instance: one new bit per clock
    bus1.pattern = 8'hA5;
    bus1.pat_len = 4'd8;
    bus1.start   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      check($sformatf("td1 k=%0d", k), vec1(), model(8'hA5, 8, 1, 1, k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
